// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel coordinates from a raw VGA stream (HS/VS plus RGB). It
//   measures every line and frame against the nominal timing, and locks once
//   it has seen one complete, well-formed frame. While locked it emits each
//   visible pixel together with its (x,y) position.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   pix_en                pixel strobe; nothing is sampled or advanced without it
//   vga_hs, vga_vs        active-low sync inputs
//   vga_r/g/b [7:0]       pixel colour inputs
//   pix_r/g/b [7:0]       captured colour, qualified by pix_valid
//   pix_x/y   [9:0]       visible-area coordinates, qualified by pix_valid
//   pix_valid             one-clk pulse per visible pixel
//   line_start            one-clk pulse at h=0 of each visible line
//   frame_start           one-clk pulse at h=0 of the first visible line
//   locked                timing has been verified
module vga_sync_decoder #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked
);

  localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
  localparam logic [10:0] V_TOTAL = 11'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
  localparam logic [10:0] H_VIS0  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_VIS1  = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_VIS0  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_VIS1  = 10'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
  state_t state, state_nxt;

  logic        s1_hs, s1_vs;
  logic [7:0]  s1_r, s1_g, s1_b;
  logic        hs_prev;    // s1_hs one sample back, for falling-edge detect
  logic        vs_at_hs;   // s1_vs as seen at the previous HS edge
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        line_err;

  logic        hs_edge, vs_edge, h_bad, h_sat, frame_ok, vis_h, vis_v, lock_nxt;
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic [11:0] h_len;
  logic [10:0] v_len;

  // Edges are qualified with pix_en so every downstream decision only moves
  // on a pixel sample.
  assign hs_edge = pix_en && !s1_hs && hs_prev;
  // VS is only looked at on HS edges; a VS fall mid-line waits for the next one.
  assign vs_edge = hs_edge && !s1_vs && vs_at_hs;

  assign h_len = {1'b0, h_cnt} + 12'd1;
  assign v_len = {1'b0, v_cnt} + 11'd1;
  assign h_bad = hs_edge && (h_len != H_TOTAL);

  always_comb begin
    h_nxt = h_cnt;
    if (hs_edge)               h_nxt = '0;
    else if (h_cnt != 11'h7FF) h_nxt = h_cnt + 11'd1;
  end

  always_comb begin
    v_nxt = v_cnt;
    if (vs_edge)                        v_nxt = '0;
    else if (hs_edge && v_cnt != 10'h3FF) v_nxt = v_cnt + 10'd1;
  end

  assign h_sat    = pix_en && (h_nxt == 11'h7FF);
  // The line closed by this same edge counts toward the frame being judged.
  assign frame_ok = (v_len == V_TOTAL) && !line_err && !h_bad;

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (vs_edge) state_nxt = CHECK;
      CHECK:    if (vs_edge) state_nxt = frame_ok ? LOCKED : UNLOCKED;
      LOCKED:   if (h_bad || h_sat || (vs_edge && !frame_ok)) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= state_nxt;
  end

  assign locked   = (state == LOCKED);
  assign lock_nxt = (state_nxt == LOCKED);
  assign vis_h    = (h_nxt >= H_VIS0) && (h_nxt < H_VIS1);
  assign vis_v    = (v_nxt >= V_VIS0) && (v_nxt < V_VIS1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_r        <= '0;
      s1_g        <= '0;
      s1_b        <= '0;
      hs_prev     <= 1'b1;
      vs_at_hs    <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_err    <= 1'b0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        s1_hs    <= vga_hs;
        s1_vs    <= vga_vs;
        s1_r     <= vga_r;
        s1_g     <= vga_g;
        s1_b     <= vga_b;
        hs_prev  <= s1_hs;
        if (hs_edge) vs_at_hs <= s1_vs;
        h_cnt    <= h_nxt;
        v_cnt    <= v_nxt;
        line_err <= vs_edge ? 1'b0 : (line_err | h_bad);
        if (lock_nxt && vis_h && vis_v) begin
          pix_valid <= 1'b1;
          pix_x     <= 10'(h_nxt - H_VIS0);
          pix_y     <= v_nxt - V_VIS0;
          pix_r     <= s1_r;
          pix_g     <= s1_g;
          pix_b     <= s1_b;
        end
        line_start  <= lock_nxt && hs_edge && vis_v;
        frame_start <= lock_nxt && hs_edge && (v_nxt == V_VIS0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a shrunken timing (17 x 8 total, 8 x 4
// visible) so whole frames stay short. The reference model works on sample
// indices and event counts: position is "samples since the last HS fall",
// line number is "HS falls since the last VS fall", and line/frame lengths
// are differences of those indices.
module tb_vga_sync_decoder;
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VSY = 1, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VSY + VB + VA + VF;
  localparam int HV0 = HS + HB;
  localparam int VV0 = VSY + VB;

  logic clk = 1'b0;
  logic reset, pix_en, vga_hs, vga_vs;
  logic [7:0] vga_r, vga_g, vga_b, pix_r, pix_g, pix_b;
  logic [9:0] pix_x, pix_y;
  logic pix_valid, line_start, frame_start, locked;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VSY), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .line_start(line_start),
    .frame_start(frame_start), .locked(locked)
  );

  always #5 clk = ~clk;

  int tests, fails;
  bit chk_on;
  int vcnt, first_x, first_y, last_x, last_y;

  // model state
  int   m_p, m_ah, m_nhs, m_av, m_st;
  bit   m_lerr;
  logic m_hs1, m_vs1, m_hsprev, m_vsat;
  logic [7:0] m_r1, m_g1, m_b1;
  // expected outputs
  logic e_valid, e_ls, e_fs, e_locked;
  logic [9:0] e_x, e_y;
  logic [7:0] e_r, e_g, e_b;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_ah = 0; m_nhs = 0; m_av = 0; m_st = 0; m_lerr = 0;
    m_hs1 = 1; m_vs1 = 1; m_hsprev = 1; m_vsat = 1;
    m_r1 = 0; m_g1 = 0; m_b1 = 0;
    e_valid = 0; e_ls = 0; e_fs = 0; e_locked = 0;
    e_x = 0; e_y = 0; e_r = 0; e_g = 0; e_b = 0;
  endtask

  // Predicts outputs after this pix_en edge; the sample being judged is the
  // one driven on the previous pix_en (m_*1), giving the two-sample latency.
  task automatic model_step(input logic hs, input logic vs, input logic [7:0] r, g, b);
    bit hs_e, vs_e, bad, ok;
    int h, v;
    m_p++;
    hs_e = !m_hs1 && m_hsprev;
    vs_e = 0; bad = 0; ok = 0;
    if (hs_e) begin
      bad   = ((m_p - m_ah) != HT);
      m_ah  = m_p;
      m_nhs++;
      vs_e  = !m_vs1 && m_vsat;
      m_vsat = m_vs1;
    end
    h = m_p - m_ah;
    if (h > 2047) h = 2047;
    if (vs_e) begin
      ok = ((m_nhs - m_av) == VT) && !m_lerr && !bad;
      m_av = m_nhs;
      m_lerr = 0;
    end else m_lerr = m_lerr | bad;
    v = m_nhs - m_av;
    if (v > 1023) v = 1023;
    case (m_st)
      0: if (vs_e) m_st = 1;
      1: if (vs_e) m_st = ok ? 2 : 0;
      default: if (bad || h == 2047 || (vs_e && !ok)) m_st = 0;
    endcase
    e_locked = (m_st == 2);
    e_valid  = e_locked && h >= HV0 && h < HV0 + HA && v >= VV0 && v < VV0 + VA;
    if (e_valid) begin
      e_x = 10'(h - HV0); e_y = 10'(v - VV0);
      e_r = m_r1; e_g = m_g1; e_b = m_b1;
    end
    e_ls = e_locked && hs_e && v >= VV0 && v < VV0 + VA;
    e_fs = e_ls && (v == VV0);
    m_hsprev = m_hs1;
    m_hs1 = hs; m_vs1 = vs; m_r1 = r; m_g1 = g; m_b1 = b;
  endtask

  task automatic samp(input logic h, input logic v, input logic [7:0] r, g, b);
    @(negedge clk);
    pix_en = 1; vga_hs = h; vga_vs = v; vga_r = r; vga_g = g; vga_b = b;
    model_step(h, v, r, g, b);
    @(negedge clk);
    pix_en = 0;
    e_valid = 0; e_ls = 0; e_fs = 0;
  endtask

  // Lines first..last of a frame; short_ln is one pixel shorter, and the VS
  // low window starts vs_shift pixels after the frame origin.
  task automatic gen(input int first, input int last, input int short_ln, input int vs_shift);
    for (int ln = first; ln <= last; ln++) begin
      int len;
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        int pos;
        pos = ln * HT + h;
        samp(h >= HS, !(pos >= vs_shift && pos < vs_shift + VSY * HT),
             8'((h - HV0) & 255), 8'(ln), 8'(h));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; pix_en = 1; vga_hs = 0; vga_vs = 0;
    model_reset();
    chk_on = 1;
    @(negedge clk);
    chk("reset_outputs", int'(pix_x) + int'(pix_y) + int'(pix_r) + int'(pix_g) + int'(pix_b)
        + int'(pix_valid) + int'(line_start) + int'(frame_start) + int'(locked), 0);
    reset = 0; pix_en = 0; vga_hs = 1; vga_vs = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      tests++;
      if ({pix_valid, line_start, frame_start, locked} !== {e_valid, e_ls, e_fs, e_locked}) begin
        fails++;
        $display("FAIL ctrl @%0t: got v/ls/fs/lk=%b%b%b%b expected %b%b%b%b", $time,
                 pix_valid, line_start, frame_start, locked, e_valid, e_ls, e_fs, e_locked);
      end
      tests++;
      if ({pix_x, pix_y, pix_r, pix_g, pix_b} !== {e_x, e_y, e_r, e_g, e_b}) begin
        fails++;
        $display("FAIL data @%0t: got x=%0d y=%0d rgb=%h%h%h expected x=%0d y=%0d rgb=%h%h%h",
                 $time, pix_x, pix_y, pix_r, pix_g, pix_b, e_x, e_y, e_r, e_g, e_b);
      end
      if (pix_valid === 1'b1) begin
        tests++;
        if (pix_r !== pix_x[7:0]) begin
          fails++;
          $display("FAIL ramp @%0t: got r=%0d expected %0d", $time, pix_r, pix_x[7:0]);
        end
        vcnt++;
        if (vcnt == 1) begin first_x = pix_x; first_y = pix_y; end
        last_x = pix_x; last_y = pix_y;
      end
    end
  end

  initial begin
    tests = 0; fails = 0; chk_on = 0; vcnt = 0;
    reset = 1; pix_en = 0; vga_hs = 1; vga_vs = 1; vga_r = 0; vga_g = 0; vga_b = 0;
    model_reset();
    do_reset();

    repeat (5) samp(1, 1, 8'h55, 8'h66, 8'h77);
    gen(0, VT - 1, -1, 0);                       // first VS edge -> CHECK
    gen(0, VT - 1, -1, 0);                       // good frame judged -> LOCKED
    chk("lock_after_2nd_vs", locked, 1);
    vcnt = 0;
    gen(0, VT - 1, -1, 0);
    chk("visible_count", vcnt, HA * VA);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("last_x", last_x, HA - 1);
    chk("last_y", last_y, VA - 1);

    gen(0, VT - 1, 3, 0);                        // one short line
    chk("unlock_short_line", locked, 0);
    vcnt = 0;
    gen(0, VT - 1, -1, 0);
    chk("no_valid_while_relocking", vcnt, 0);
    gen(0, VT - 1, -1, 0);
    chk("relock_short_line", locked, 1);

    vcnt = 0;
    repeat (2100) samp(1, 1, 8'h00, 8'h00, 8'h00); // HS stuck high
    chk("unlock_h_saturation", locked, 0);
    chk("no_valid_saturation", vcnt, 0);
    gen(0, VT - 1, -1, 0);
    gen(0, VT - 1, -1, 0);
    chk("relock_after_saturation", locked, 1);

    gen(0, 4, -1, 0);                            // reset mid-frame
    do_reset();
    gen(5, VT - 1, -1, 0);
    chk("unlocked_after_reset", locked, 0);
    gen(0, VT - 1, -1, 0);
    chk("check_after_reset", locked, 0);
    gen(0, VT - 1, -1, 0);
    chk("relock_after_reset", locked, 1);

    gen(0, VT - 2, -1, 0);                       // frame one line short
    chk("still_locked_before_judging", locked, 1);
    gen(0, VT - 1, -1, 0);
    chk("unlock_short_frame", locked, 0);
    gen(0, VT - 2, -1, 0);                       // short frame while in CHECK
    gen(0, VT - 1, -1, 0);
    chk("check_to_unlocked", locked, 0);
    gen(0, VT - 1, -1, 0);
    gen(0, VT - 1, -1, 0);
    chk("relock_short_frame", locked, 1);

    gen(0, VT - 1, -1, 5);                       // VS falls mid-line
    chk("unlock_late_vs", locked, 0);
    gen(0, VT - 1, -1, 0);
    gen(0, VT - 1, -1, 0);
    chk("relock_late_vs", locked, 1);

    repeat (4) samp(1, 1, 8'h00, 8'h00, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
